// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus: a req/ack handshake with the address held
// stable until the ack arrives.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register. It fetches from variable-latency imem, follows the
// predictor's next_pc, and parks a stalled fetch in a one-entry skid buffer.
module fetch_stage #(
    parameter int          ENTRY_BIT = 5,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] NOP_INST  = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        imem,
    input  logic [31:0]          bp_next_pc,
    input  logic                 bp_is_flush,
    input  logic [ENTRY_BIT-1:0] bp_current_bhsr,
    input  logic                 hazard_stall,
    output logic [31:0]          current_pc,
    output logic                 IF_ID_valid,
    output logic [31:0]          IF_ID_inst,
    output logic [31:0]          IF_ID_pc,
    output logic [ENTRY_BIT-1:0] IF_ID_bhsr
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    typedef struct packed {
        logic [31:0]          inst;
        logic [31:0]          pc;
        logic [ENTRY_BIT-1:0] bhsr;
    } snap_t;

    logic [1:0]  state;
    logic [31:0] req_addr;
    snap_t       skid;
    snap_t       snap;
    logic        accept;

    assign imem.imem_req  = (state == BUSY) || (state == DRAIN);
    assign imem.imem_addr = req_addr;

    // The skid buffer is full exactly while in HOLD, so no separate valid bit is kept.
    always_comb begin
        snap   = (state == HOLD) ? skid
                                 : '{inst: imem.imem_rdata, pc: current_pc, bhsr: bp_current_bhsr};
        accept = !bp_is_flush && !hazard_stall &&
                 ((state == HOLD) || (state == BUSY && imem.imem_ack));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            current_pc  <= RESET_PC;
            req_addr    <= RESET_PC;
            skid        <= '0;
            IF_ID_valid <= 1'b0;
            IF_ID_inst  <= NOP_INST;
            IF_ID_pc    <= '0;
            IF_ID_bhsr  <= '0;
        end else if (bp_is_flush) begin
            IF_ID_valid <= 1'b0;
            IF_ID_inst  <= NOP_INST;
            current_pc  <= bp_next_pc;
            // An in-flight request must complete on its original address first.
            if (state == DRAIN || (state == BUSY && !imem.imem_ack)) begin
                state <= DRAIN;
            end else begin
                state    <= BUSY;
                req_addr <= bp_next_pc;
            end
        end else if (accept) begin
            IF_ID_valid <= 1'b1;
            IF_ID_inst  <= snap.inst;
            IF_ID_pc    <= snap.pc;
            IF_ID_bhsr  <= snap.bhsr;
            current_pc  <= bp_next_pc;
            req_addr    <= bp_next_pc;
            state       <= BUSY;
        end else begin
            case (state)
                IDLE: begin
                    state    <= BUSY;
                    req_addr <= current_pc;
                end
                BUSY: if (imem.imem_ack) begin
                    skid  <= snap;
                    state <= HOLD;
                end
                DRAIN: if (imem.imem_ack) begin
                    req_addr <= current_pc;
                    state    <= BUSY;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table, followed by a reset-mid-drain sequence.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] KEY = 32'hDEAD0000;

    logic        clk;
    logic        reset;
    logic        ack, stall, flush_en;
    logic [31:0] flush_tgt;
    logic [31:0] bp_next_pc;
    logic [4:0]  bp_bhsr;
    logic [31:0] current_pc, IF_ID_inst, IF_ID_pc;
    logic        IF_ID_valid;
    logic [4:0]  IF_ID_bhsr;
    int          n_vec, n_bad;

    fetch_stage_if bus();

    assign bus.imem_ack   = ack;
    assign bus.imem_rdata = bus.imem_addr ^ KEY;
    assign bp_next_pc     = flush_en ? flush_tgt : current_pc + 32'd4;
    assign bp_bhsr        = current_pc[6:2] ^ 5'h15;

    fetch_stage #(.ENTRY_BIT(5), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset), .imem(bus),
        .bp_next_pc(bp_next_pc), .bp_is_flush(flush_en), .bp_current_bhsr(bp_bhsr),
        .hazard_stall(stall), .current_pc(current_pc),
        .IF_ID_valid(IF_ID_valid), .IF_ID_inst(IF_ID_inst),
        .IF_ID_pc(IF_ID_pc), .IF_ID_bhsr(IF_ID_bhsr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ack, stall, flush;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc, cur;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t v(logic a, logic s, logic f, logic [31:0] t,
                               logic r, logic [31:0] ad, logic vl, logic [31:0] p, logic [31:0] c);
        vec_t x;
        x.ack = a; x.stall = s; x.flush = f; x.tgt = t;
        x.req = r; x.addr = ad; x.valid = vl; x.pc = p; x.cur = c;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] e_inst;
        logic [4:0]  e_bhsr;
        logic        ok;
        n_vec = 0; n_bad = 0;
        //          ack stl fl tgt        req addr      vld pc        cur
        vecs[0]  = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0);
        vecs[1]  = v(1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0);
        vecs[2]  = v(1, 0, 0, 32'h0,   1, 32'h4,   1, 32'h0,   32'h4);
        vecs[3]  = v(1, 0, 0, 32'h0,   1, 32'h8,   1, 32'h4,   32'h8);
        vecs[4]  = v(1, 0, 1, 32'h10,  1, 32'hC,   1, 32'h8,   32'hC);
        vecs[5]  = v(0, 0, 0, 32'h0,   1, 32'h10,  0, 32'h8,   32'h10);
        vecs[6]  = v(0, 0, 0, 32'h0,   1, 32'h10,  0, 32'h8,   32'h10);
        vecs[7]  = v(0, 1, 0, 32'h0,   1, 32'h10,  0, 32'h8,   32'h10);
        vecs[8]  = v(1, 0, 0, 32'h0,   1, 32'h10,  0, 32'h8,   32'h10);
        vecs[9]  = v(1, 1, 0, 32'h0,   1, 32'h14,  1, 32'h10,  32'h14);
        vecs[10] = v(0, 1, 0, 32'h0,   0, 32'h14,  1, 32'h10,  32'h14);
        vecs[11] = v(0, 0, 0, 32'h0,   0, 32'h14,  1, 32'h10,  32'h14);
        vecs[12] = v(1, 0, 0, 32'h0,   1, 32'h18,  1, 32'h14,  32'h18);
        vecs[13] = v(1, 0, 1, 32'h40,  1, 32'h1C,  1, 32'h18,  32'h1C);
        vecs[14] = v(0, 0, 1, 32'h200, 1, 32'h40,  0, 32'h18,  32'h40);
        vecs[15] = v(0, 0, 0, 32'h0,   1, 32'h40,  0, 32'h18,  32'h200);
        vecs[16] = v(1, 0, 0, 32'h0,   1, 32'h40,  0, 32'h18,  32'h200);
        vecs[17] = v(1, 0, 0, 32'h0,   1, 32'h200, 0, 32'h18,  32'h200);
        vecs[18] = v(1, 1, 0, 32'h0,   1, 32'h204, 1, 32'h200, 32'h204);
        vecs[19] = v(0, 1, 1, 32'h200, 0, 32'h204, 1, 32'h200, 32'h204);
        vecs[20] = v(1, 0, 0, 32'h0,   1, 32'h200, 0, 32'h200, 32'h200);
        vecs[21] = v(0, 0, 0, 32'h0,   1, 32'h204, 1, 32'h200, 32'h204);

        reset = 1'b0; ack = 1'b0; stall = 1'b0; flush_en = 1'b0; flush_tgt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            ack = vecs[i].ack; stall = vecs[i].stall;
            flush_en = vecs[i].flush; flush_tgt = vecs[i].tgt;
            #1;
            e_inst = vecs[i].valid ? (vecs[i].pc ^ KEY) : NOP;
            e_bhsr = vecs[i].pc[6:2] ^ 5'h15;
            ok = (bus.imem_req === vecs[i].req) && (bus.imem_addr === vecs[i].addr) &&
                 (IF_ID_valid === vecs[i].valid) && (IF_ID_pc === vecs[i].pc) &&
                 (current_pc === vecs[i].cur) && (IF_ID_inst === e_inst) &&
                 (!vecs[i].valid || IF_ID_bhsr === e_bhsr);
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec%0d: got req=%b addr=%h vld=%b pc=%h cur=%h inst=%h bhsr=%h want req=%b addr=%h vld=%b pc=%h cur=%h inst=%h bhsr=%h",
                         i, bus.imem_req, bus.imem_addr, IF_ID_valid, IF_ID_pc, current_pc, IF_ID_inst, IF_ID_bhsr,
                         vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].pc, vecs[i].cur, e_inst, e_bhsr);
            end
            @(negedge clk);
        end

        // Redirect twice while draining: the old address stays on the bus and the latest target wins.
        ack = 1'b0; stall = 1'b0; flush_en = 1'b1; flush_tgt = 32'h300;
        @(negedge clk);
        flush_tgt = 32'h380;
        @(negedge clk);
        flush_en = 1'b0;
        #1;
        check("drain_req",  {31'b0, bus.imem_req}, 32'd1);
        check("drain_addr", bus.imem_addr, 32'h204);
        check("drain_cur",  current_pc, 32'h380);

        // Asynchronous reset in the middle of a cycle.
        #1 reset = 1'b0;
        #1;
        check("rst_req",   {31'b0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'b0, IF_ID_valid}, 32'd0);
        check("rst_cur",   current_pc, 32'h0);
        check("rst_inst",  IF_ID_inst, NOP);

        // A stale ack held across release must not be accepted in IDLE.
        ack = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_valid", {31'b0, IF_ID_valid}, 32'd0);
        check("idle_req",   {31'b0, bus.imem_req}, 32'd1);
        check("idle_addr",  bus.imem_addr, 32'h0);
        @(negedge clk);
        check("first_valid", {31'b0, IF_ID_valid}, 32'd1);
        check("first_pc",    IF_ID_pc, 32'h0);
        check("first_inst",  IF_ID_inst, KEY);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
